crc5_frame_chk: RTL and testbench
=================================

# crc5_frame_chk

- Receive-side CRC-5 checker for byte framing, paired with the 8-bit serial CRC-5 generator (polynomial x^5+x^4+x^2+1, init 0, MSB first, no reflection, no final XOR).
- Accepts payload bytes through a valid/ready handshake and runs the CRC serially, one bit per cycle.
- Takes the trailing CRC byte and compares its [4:0] against the computed value.
- Reports the pass/fail verdict plus frame length to the downstream frame consumer.

## Interface
- MAX_BYTES, 16: maximum payload bytes per frame (1..255); more is a length error.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  payload byte, or the CRC byte when in_last=1 (CRC in [4:0], [7:5] ignored).
- in_valid  in  1  in_data valid.
- in_last  in  1  qualifies the CRC byte, which closes the frame.
- in_ready  out  1  block accepts a byte this cycle.
- busy  out  1  frame in progress (first byte accepted, verdict not yet issued).
- frame_done  out  1  one-cycle pulse: verdict valid.
- crc_ok  out  1  computed CRC equals received CRC and no length error; held until next frame start.
- crc_err  out  1  mismatch or length error; held until next frame start.
- len_err  out  1  payload exceeded MAX_BYTES; held until next frame start.
- calc_crc  out  5  computed CRC of the payload; held.
- rx_crc  out  5  received CRC; held.
- byte_cnt  out  8  payload bytes accepted in current/last frame, saturating at 255.

## Operation
- States: IDLE, SHIFT, WAIT, RESULT. in_ready=1 only in IDLE and WAIT; it is decoded from state.
- Handshake: a byte transfers on a rising edge with in_valid & in_ready. in_valid is ignored when in_ready=0.
- IDLE, payload byte accepted (in_last=0):
  - Clear crc_ok/crc_err/len_err; crc reg := 0; byte_cnt := 1.
  - Latch byte into shift reg; busy := 1; go SHIFT.
- IDLE, CRC byte accepted (in_last=1), i.e. empty frame:
  - Clear flags; byte_cnt := 0; calc_crc = 0.
  - rx_crc := in_data[4:0]; busy := 1; go RESULT.
- SHIFT: 8 cycles, 3-bit counter, one data bit per cycle, MSB first:
  - fb = crc[4] ^ bit.
  - crc := {crc[3:0],0} ^ (fb ? 5'b10101 : 0).
  - After the 8th bit go WAIT.
- WAIT, payload byte accepted:
  - byte_cnt increments, saturating.
  - If byte_cnt was already MAX_BYTES: len_err := 1, byte discarded (no SHIFT), stay WAIT.
  - Otherwise go SHIFT.
- WAIT, CRC byte accepted: rx_crc := in_data[4:0]; go RESULT.
- RESULT, one cycle:
  - frame_done=1.
  - crc_ok = (calc_crc==rx_crc) & ~len_err; crc_err = ~crc_ok.
  - busy := 0; go IDLE.
- calc_crc tracks the CRC register continuously. Its final value is stable from WAIT onward.
- No timeout: WAIT holds indefinitely.
- Async reset mid-frame:
  - Immediate return to IDLE; partial frame dropped.
  - No frame_done for the dropped frame.

## Timing
- Reset values: in_ready=1 after reset release (IDLE); in_ready=0 while rst_n=0.
- Reset values of all other outputs: busy=0, frame_done=0, crc_ok=0, crc_err=0, len_err=0, calc_crc=0, rx_crc=0, byte_cnt=0.
- Payload byte accepted at edge N:
  - in_ready=0 for cycles N+1..N+8.
  - in_ready=1 again in cycle N+9; next accept no earlier than edge N+9.
  - Throughput: 9 cycles per payload byte.
- CRC byte accepted at edge M: frame_done=1 and verdict flags valid in cycle M+1, registered outputs.
- in_ready=0 during RESULT. A new frame may start at edge M+2.
- Overflow byte in WAIT: 1 cycle, in_ready stays 1.
- crc_ok/crc_err never both 1. Both are 0 from first accept of a frame until its frame_done.

## Test plan
- Single byte 0x80, then CRC byte 0x1C, in_valid held:
  - Required: frame_done exactly once, crc_ok=1, calc_crc=0x1C, byte_cnt=1.
  - Required: in_ready low 8 cycles after the payload accept.
- Single byte 0x01, then CRC byte 0x14:
  - Required: calc_crc=0x15, rx_crc=0x14, crc_err=1, crc_ok=0.
- Bytes 0x80,0x01, then CRC byte 0xE0 ([7:5] junk):
  - Required: calc_crc=0x00, rx_crc=0x00, crc_ok=1, byte_cnt=2.
- Empty frame, CRC byte 0x00 with in_last on first byte:
  - Required: frame_done in the next cycle, crc_ok=1, byte_cnt=0.
- MAX_BYTES=16, 17 payload bytes of 0x00, then CRC byte 0x00:
  - Required: len_err=1, crc_err=1, crc_ok=0, calc_crc=0x00, byte_cnt=17.
- rst_n pulsed low during SHIFT of byte 2:
  - Required: all outputs at reset values, no frame_done.
  - Required: next frame 0x80 + CRC byte 0x1C yields crc_ok=1.

Source files
------------

// File: rtl/crc5_frame_chk_if.sv
// Byte-stream and verdict bundle shared between the frame source/consumer
// (master) and the CRC-5 frame checker (slave).
interface crc5_frame_chk_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       busy;
  logic       frame_done;
  logic       crc_ok;
  logic       crc_err;
  logic       len_err;
  logic [4:0] calc_crc;
  logic [4:0] rx_crc;
  logic [7:0] byte_cnt;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, busy, frame_done, crc_ok, crc_err, len_err,
           calc_crc, rx_crc, byte_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, busy, frame_done, crc_ok, crc_err, len_err,
           calc_crc, rx_crc, byte_cnt
  );
endinterface

// File: rtl/crc5_frame_chk.sv
// Receive-side CRC-5 frame checker (x^5+x^4+x^2+1, init 0, MSB first).
// Payload bytes are shifted through the CRC one bit per cycle; the trailing
// byte flagged by in_last carries the expected CRC in [4:0].
module crc5_frame_chk #(
  parameter int unsigned MAX_BYTES = 16
) (
  input logic             clk,
  input logic             rst_n,
  crc5_frame_chk_if.slave frm
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);
  localparam logic [4:0] POLY    = 5'b10101;

  // One serial CRC-5 step for a single input bit.
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic bit_in);
    logic fb;
    fb = crc[4] ^ bit_in;
    return {crc[3:0], 1'b0} ^ (fb ? POLY : 5'b00000);
  endfunction

  state_t     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [4:0] crc_q;
  logic [4:0] rx_crc_q;
  logic [7:0] byte_cnt_q;
  logic       busy_q;
  logic       frame_done_q;
  logic       crc_ok_q;
  logic       crc_err_q;
  logic       len_err_q;

  logic       in_ready_s;
  logic       accept_s;
  logic [4:0] crc_d;
  logic [7:0] byte_cnt_inc_d;
  logic       wait_ok_d;
  logic       empty_ok_d;

  // in_ready is a pure state decode, forced low while reset is asserted.
  assign in_ready_s     = rst_n & ((state_q == ST_IDLE) | (state_q == ST_WAIT));
  assign accept_s       = frm.in_valid & in_ready_s;
  assign crc_d          = crc5_step(crc_q, shift_q[7]);
  assign byte_cnt_inc_d = (byte_cnt_q == 8'hFF) ? 8'hFF : (byte_cnt_q + 8'd1);
  // The CRC register is final once in WAIT, so the verdict can be formed
  // on the same edge that accepts the CRC byte.
  assign wait_ok_d      = (crc_q == frm.in_data[4:0]) & ~len_err_q;
  assign empty_ok_d     = (frm.in_data[4:0] == 5'b00000);

  // Frame FSM: byte intake, serial CRC, length policing and verdict registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      crc_q        <= 5'b00000;
      rx_crc_q     <= 5'b00000;
      byte_cnt_q   <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            busy_q    <= 1'b1;
            len_err_q <= 1'b0;
            crc_q     <= 5'b00000;
            if (frm.in_last) begin
              // Empty frame: verdict straight from the received CRC.
              byte_cnt_q   <= 8'h00;
              rx_crc_q     <= frm.in_data[4:0];
              crc_ok_q     <= empty_ok_d;
              crc_err_q    <= ~empty_ok_d;
              frame_done_q <= 1'b1;
              state_q      <= ST_RESULT;
            end else begin
              crc_ok_q   <= 1'b0;
              crc_err_q  <= 1'b0;
              byte_cnt_q <= 8'd1;
              shift_q    <= frm.in_data;
              bit_cnt_q  <= 3'd0;
              state_q    <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          crc_q     <= crc_d;
          shift_q   <= {shift_q[6:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (accept_s) begin
            if (frm.in_last) begin
              rx_crc_q     <= frm.in_data[4:0];
              crc_ok_q     <= wait_ok_d;
              crc_err_q    <= ~wait_ok_d;
              frame_done_q <= 1'b1;
              state_q      <= ST_RESULT;
            end else begin
              byte_cnt_q <= byte_cnt_inc_d;
              if (byte_cnt_q >= MAX_CNT) begin
                // Overflow byte: counted and flagged, never hashed.
                len_err_q <= 1'b1;
              end else begin
                shift_q   <= frm.in_data;
                bit_cnt_q <= 3'd0;
                state_q   <= ST_SHIFT;
              end
            end
          end
        end
        ST_RESULT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign frm.in_ready   = in_ready_s;
  assign frm.busy       = busy_q;
  assign frm.frame_done = frame_done_q;
  assign frm.crc_ok     = crc_ok_q;
  assign frm.crc_err    = crc_err_q;
  assign frm.len_err    = len_err_q;
  assign frm.calc_crc   = crc_q;
  assign frm.rx_crc     = rx_crc_q;
  assign frm.byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_crc5_frame_chk.sv
// Scoreboard bench for crc5_frame_chk: the driver queues the expected verdict
// for every CRC byte it sends, a monitor pops and compares on frame_done.
module tb_crc5_frame_chk;

  typedef struct {
    logic       ok;
    logic       err;
    logic       len;
    logic [4:0] calc;
    logic [4:0] rx;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_cnt;
  int   done_before;
  exp_t sb_q[$];

  crc5_frame_chk_if frm ();

  crc5_frame_chk #(.MAX_BYTES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .frm   (frm.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (frm.frame_done === 1'b1) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("crc_ok",   int'(frm.crc_ok),   int'(e.ok));
          check("crc_err",  int'(frm.crc_err),  int'(e.err));
          check("len_err",  int'(frm.len_err),  int'(e.len));
          check("calc_crc", int'(frm.calc_crc), int'(e.calc));
          check("rx_crc",   int'(frm.rx_crc),   int'(e.rx));
          check("byte_cnt", int'(frm.byte_cnt), int'(e.cnt));
          check("busy_at_done", int'(frm.busy), 1);
        end
      end
    end
  endtask

  task automatic drive_until_accept(input logic [7:0] d, input logic last);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    @(negedge clk);
    frm.in_data  = d;
    frm.in_last  = last;
    frm.in_valid = 1'b1;
    while (!acc && n < 40) begin
      acc = (frm.in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    check("accept", int'(acc), 1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive_until_accept(d, 1'b0);
  endtask

  task automatic send_crc(input logic [7:0] d, input exp_t e);
    sb_q.push_back(e);
    drive_until_accept(d, 1'b1);
    @(negedge clk);
    check("done_latency", int'(frm.frame_done), 1);
    frm.in_valid = 1'b0;
    frm.in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready",   int'(frm.in_ready),   0);
    check("rst_busy",       int'(frm.busy),       0);
    check("rst_frame_done", int'(frm.frame_done), 0);
    check("rst_crc_ok",     int'(frm.crc_ok),     0);
    check("rst_crc_err",    int'(frm.crc_err),    0);
    check("rst_len_err",    int'(frm.len_err),    0);
    check("rst_calc_crc",   int'(frm.calc_crc),   0);
    check("rst_rx_crc",     int'(frm.rx_crc),     0);
    check("rst_byte_cnt",   int'(frm.byte_cnt),   0);
  endtask

  // Directed stimulus; the monitor runs alongside as a forked process.
  initial begin
    checks       = 0;
    errors       = 0;
    done_cnt     = 0;
    rst_n        = 1'b0;
    frm.in_data  = 8'h00;
    frm.in_valid = 1'b0;
    frm.in_last  = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", int'(frm.in_ready), 1);

    // 0x80 -> CRC 0x1C, in_valid held across the SHIFT phase.
    send_byte(8'h80);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("ready_low_shift", int'(frm.in_ready), 0);
      if (i == 0) check("busy_in_frame", int'(frm.busy), 1);
    end
    send_crc(8'h1C, '{ok:1'b1, err:1'b0, len:1'b0, calc:5'h1C, rx:5'h1C, cnt:8'd1});
    repeat (2) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("busy_cleared", int'(frm.busy), 0);

    // 0x01 -> CRC 0x15, received 0x14: mismatch.
    send_byte(8'h01);
    send_crc(8'h14, '{ok:1'b0, err:1'b1, len:1'b0, calc:5'h15, rx:5'h14, cnt:8'd1});
    repeat (3) @(negedge clk);
    check("err_held", int'(frm.crc_err), 1);

    // 0x80,0x01 -> CRC 0x00; CRC byte carries junk in [7:5].
    send_byte(8'h80);
    send_byte(8'h01);
    send_crc(8'hE0, '{ok:1'b1, err:1'b0, len:1'b0, calc:5'h00, rx:5'h00, cnt:8'd2});

    // Empty frame.
    send_crc(8'h00, '{ok:1'b1, err:1'b0, len:1'b0, calc:5'h00, rx:5'h00, cnt:8'd0});

    // 17 zero bytes with MAX_BYTES=16: length error.
    for (int i = 0; i < 17; i++) send_byte(8'h00);
    send_crc(8'h00, '{ok:1'b0, err:1'b1, len:1'b1, calc:5'h00, rx:5'h00, cnt:8'd17});
    repeat (2) @(negedge clk);
    check("done_count_5", done_cnt, 5);

    // Reset pulse during SHIFT of the second byte.
    send_byte(8'h80);
    send_byte(8'h01);
    repeat (3) @(negedge clk);
    done_before = done_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    frm.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", done_cnt, done_before);
    check("idle_after_reset", int'(frm.busy), 0);
    check("cnt_after_reset", int'(frm.byte_cnt), 0);

    send_byte(8'h80);
    send_crc(8'h1C, '{ok:1'b1, err:1'b0, len:1'b0, calc:5'h1C, rx:5'h1C, cnt:8'd1});
    repeat (4) @(negedge clk);
    check("done_count_total", done_cnt, 6);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
